// File: rtl/counter_history.sv
// Purpose : up/down counter with parallel load, terminal-count pulse plus saturating
//           event tally, and a DEPTH-entry circular history of pre-update counts.
// Latency : count/tc outputs update on the edge that samples en/load; history read
//           data appears one cycle after rd_en (rd_valid). No backpressure: every
//           rd_en gets exactly one response, back-to-back reads are accepted.
//
// Ports:
//   clk, rst_n          single rising-edge clock, synchronous active-low reset
//   en, dir             step the counter (dir 0 = up, 1 = down)
//   load, load_val      parallel load, wins over en, never writes history
//   count               registered counter value
//   tc_pulse, tc_count  one-cycle pulse when count first shows TERMINAL, saturating tally
//   rd_en, rd_age       history read request, age 0 = newest entry
//   rd_data, rd_valid,  read response; rd_hit = 0 means the age is beyond the
//   rd_hit              fill level and rd_data is forced to zero
//   fill                number of valid history entries, saturates at DEPTH
module counter_history #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int TERMINAL = 255,
    parameter int TCW      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_val,
    output logic [WIDTH-1:0]           count,
    output logic                       tc_pulse,
    output logic [TCW-1:0]             tc_count,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_age,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       rd_hit,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);
    localparam logic [AW:0]      FILL_MAX = (AW+1)'(DEPTH);

    // History storage; deliberately not reset, fill gating hides stale entries.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;

    logic [WIDTH-1:0] count_next;
    logic             step;
    logic             tc_next;
    logic [AW-1:0]    rd_addr;
    logic             rd_hit_c;

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            count_next = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
        end
    end

    assign step    = en & ~load;
    // Pulse only on the transition into TERMINAL, so reloading TERMINAL is silent.
    assign tc_next = (count_next == TERM_VAL) && (count_next != count);

    // Address and hit use the pre-write pointer/fill, so a read that coincides
    // with a write sees history as it stood before this cycle's entry.
    assign rd_addr  = wptr - AW'(1) - rd_age;
    assign rd_hit_c = ({1'b0, rd_age} < fill);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            tc_pulse <= 1'b0;
            tc_count <= '0;
            wptr     <= '0;
            fill     <= '0;
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
        end else begin
            count    <= count_next;
            tc_pulse <= tc_next;
            if (tc_next && (tc_count != {TCW{1'b1}})) begin
                tc_count <= tc_count + TCW'(1);
            end
            if (step) begin
                wptr <= wptr + AW'(1);
                if (fill != FILL_MAX) begin
                    fill <= fill + (AW+1)'(1);
                end
            end
            rd_valid <= rd_en;
            // Without a request the last response is held.
            if (rd_en) begin
                rd_hit  <= rd_hit_c;
                rd_data <= rd_hit_c ? mem[rd_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && step) begin
            mem[wptr] <= count;
        end
    end

endmodule

// File: tb/tb_counter_history.sv
module tb_counter_history;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc_pulse;
    logic [15:0] tc_count;
    logic       rd_en;
    logic [3:0] rd_age;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_hit;
    logic [4:0] fill;

    int n_assert = 0;
    int n_fail   = 0;

    counter_history #(
        .WIDTH(8), .DEPTH(16), .TERMINAL(255), .TCW(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .count(count), .tc_pulse(tc_pulse),
        .tc_count(tc_count), .rd_en(rd_en), .rd_age(rd_age),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_hit(rd_hit), .fill(fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en = 0; dir = 0; load = 0; load_val = 0; rd_en = 0; rd_age = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic steps(input int n, input logic d);
        en = 1; dir = d;
        for (int i = 0; i < n; i++) tick();
        en = 0; dir = 0;
    endtask

    task automatic read_age(input logic [3:0] age, input logic exp_hit,
                            input logic [7:0] exp_data, input string tag);
        rd_en = 1; rd_age = age;
        tick();
        rd_en = 0;
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_hit"},   rd_hit,   exp_hit);
        chk({tag, "_data"},  rd_data,  exp_data);
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_count",    count,    0);
        chk("rst_fill",     fill,     0);
        chk("rst_tc_pulse", tc_pulse, 0);
        chk("rst_tc_count", tc_count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_hit",   rd_hit,   0);
        chk("rst_rd_data",  rd_data,  0);

        // 20 up-steps: history keeps pre-values 4..19, newest first on readback
        steps(20, 0);
        chk("up20_count", count, 20);
        chk("up20_fill",  fill,  16);
        chk("up20_tcc",   tc_count, 0);
        rd_en = 1;
        for (int a = 0; a < 16; a++) begin
            rd_age = 4'(a);
            tick();
            chk("b2b_valid", rd_valid, 1);
            chk("b2b_hit",   rd_hit,   1);
            chk("b2b_data",  rd_data,  32'(19 - a));
        end
        rd_en = 0;
        tick();
        chk("idle_valid", rd_valid, 0);
        chk("idle_hold",  rd_data,  4);

        // Partial fill: three entries 0,1,2
        do_reset();
        steps(3, 0);
        chk("p3_fill", fill, 3);
        read_age(4'd3, 0, 8'd0, "p3_age3");
        read_age(4'd2, 1, 8'd0, "p3_age2");
        read_age(4'd0, 1, 8'd2, "p3_age0");

        // Load 250, then 10 up-steps through the terminal count and wrap
        load = 1; load_val = 8'd250;
        tick();
        load = 0;
        chk("ld250_count", count, 250);
        chk("ld250_fill",  fill,  3);
        chk("ld250_pulse", tc_pulse, 0);
        en = 1; dir = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("wrap_count", count, 32'((250 + i) % 256));
            chk("wrap_pulse", tc_pulse, ((250 + i) == 255) ? 1 : 0);
        end
        en = 0;
        chk("wrap_tcc",  tc_count, 1);
        chk("wrap_fill", fill, 13);
        steps(256, 0);
        chk("lap_count", count, 4);
        chk("lap_tcc",   tc_count, 2);
        chk("lap_fill",  fill, 16);

        // Count down from 0 wraps to TERMINAL and pulses
        load = 1; load_val = 8'd0;
        tick();
        load = 0;
        chk("ld0_count", count, 0);
        chk("ld0_pulse", tc_pulse, 0);
        steps(1, 1);
        chk("dn_count", count, 255);
        chk("dn_pulse", tc_pulse, 1);
        chk("dn_tcc",   tc_count, 3);
        read_age(4'd0, 1, 8'd0, "dn_age0");
        load = 1; load_val = 8'd255;
        tick();
        load = 0;
        chk("ld255_pulse", tc_pulse, 0);
        chk("ld255_count", count, 255);
        chk("ld255_tcc",   tc_count, 3);

        // Load has priority over en and writes no history
        load = 1; en = 1; load_val = 8'd7;
        tick();
        load = 0; en = 0;
        chk("lden_count", count, 7);
        chk("lden_fill",  fill,  16);
        read_age(4'd0, 1, 8'd0, "lden_age0");
        read_age(4'd1, 1, 8'd3, "lden_age1");

        // Read coincident with a write sees the previous newest entry, not 5
        load = 1; load_val = 8'd5;
        tick();
        load = 0;
        en = 1; dir = 0; rd_en = 1; rd_age = 4'd0;
        tick();
        en = 0; rd_en = 0;
        chk("rw_count", count, 6);
        chk("rw_valid", rd_valid, 1);
        chk("rw_hit",   rd_hit, 1);
        chk("rw_data",  rd_data, 0);
        read_age(4'd0, 1, 8'd5, "rw_after");

        // Reset with a read request in flight drops it
        rd_en = 1; rd_age = 4'd0; rst_n = 0;
        tick();
        rd_en = 0; rst_n = 1;
        chk("rstrd_valid", rd_valid, 0);
        chk("rstrd_fill",  fill, 0);
        chk("rstrd_count", count, 0);
        chk("rstrd_tcc",   tc_count, 0);
        read_age(4'd0, 0, 8'd0, "stale_age0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
